// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style LCD bus receiver keeping a 2x16 display RAM shadow, AC and control flags
module lcd_bus_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_1MHz,
  input  logic       RST,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [6:0] AC,
  output logic       DISPLAY_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       INC_MODE,
  output logic [2:0] FUNC_BITS,
  output logic       BUSY,
  output logic       WR_STROBE,
  output logic [6:0] WR_ADDR,
  output logic [7:0] WR_CHAR,
  output logic       CMD_STROBE,
  output logic [7:0] CMD_CODE,
  output logic       READ_SEEN,
  output logic       OVERRUN
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t r_state;
  logic [SYNC_STAGES:0] r_sync;
  logic [4:0] r_fill_idx;
  logic [7:0] r_ram [32];
  logic w_event, w_mapped;
  logic [4:0] w_cell;
  logic [6:0] w_ac_inc, w_ac_dec, w_ac_step;
  // top bit is the previous value of the last synchronizer stage
  assign w_event = r_sync[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1];
  assign w_ac_inc = AC == 7'h27 ? 7'h40 : AC == 7'h67 ? 7'h00 : AC + 7'd1;
  assign w_ac_dec = AC == 7'h40 ? 7'h27 : AC == 7'h00 ? 7'h67 : AC - 7'd1;
  assign w_ac_step = INC_MODE ? w_ac_inc : w_ac_dec;
  assign w_mapped = AC[6:4] == 3'b000 || AC[6:4] == 3'b100;
  assign w_cell = {AC[6], AC[3:0]};
  assign BUSY = r_state == FILL;
  always_ff @(posedge CLK_1MHz) begin
    WR_STROBE <= 1'b0;
    CMD_STROBE <= 1'b0;
    READ_SEEN <= 1'b0;
    OVERRUN <= 1'b0;
    RD_CHAR <= r_ram[RD_ADDR];
    if (RST) begin
      r_state <= FILL;
      r_fill_idx <= '0;
      r_sync <= '0;
      AC <= '0;
      INC_MODE <= 1'b1;
      DISPLAY_ON <= 1'b0;
      CURSOR_ON <= 1'b0;
      BLINK_ON <= 1'b0;
      FUNC_BITS <= '0;
      WR_ADDR <= '0;
      WR_CHAR <= '0;
      CMD_CODE <= '0;
      RD_CHAR <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-1:0], LCD_E};
      if (r_state == FILL) begin
        r_ram[r_fill_idx] <= 8'h20;
        r_fill_idx <= r_fill_idx + 5'd1;
        if (r_fill_idx == 5'd31) r_state <= IDLE;
        OVERRUN <= w_event;
      end else if (w_event) begin
        if (LCD_RW) READ_SEEN <= 1'b1;
        else if (LCD_RS) begin
          WR_STROBE <= 1'b1;
          WR_ADDR <= AC;
          WR_CHAR <= LCD_DATA;
          if (w_mapped) r_ram[w_cell] <= LCD_DATA;
          AC <= w_ac_step;
        end else begin
          CMD_STROBE <= 1'b1;
          CMD_CODE <= LCD_DATA;
          casez (LCD_DATA)
            8'b1???????: AC <= LCD_DATA[6:0];
            8'b001?????: FUNC_BITS <= LCD_DATA[4:2];
            8'b0001????: if (!LCD_DATA[3]) AC <= LCD_DATA[2] ? w_ac_inc : w_ac_dec;
            8'b00001???: {DISPLAY_ON, CURSOR_ON, BLINK_ON} <= LCD_DATA[2:0];
            8'b000001??: INC_MODE <= LCD_DATA[1];
            8'b0000001?: AC <= '0;
            8'b00000001: begin
              AC <= '0;
              INC_MODE <= 1'b1;
              r_state <= FILL;
              r_fill_idx <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: table-driven bus transactions with a strobe scoreboard plus directed fill/clear/reset corners
`timescale 1ns/1ps
module tb_lcd_bus_responder;
  localparam logic [3:0] K_WR = 4'b0001, K_CMD = 4'b0010, K_RD = 4'b0100, K_OV = 4'b1000;
  typedef struct {
    logic [3:0] kind;
    logic [6:0] addr;
    logic [7:0] val;
  } exp_t;
  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic [3:0] kind;
    logic [6:0] wa;
    logic [6:0] ac;
    logic       inc;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, wr_char, cmd_code;
  logic [6:0] ac, wr_addr;
  logic display_on, cursor_on, blink_on, inc_mode, busy, wr_strobe, cmd_strobe, read_seen, overrun;
  logic [2:0] func_bits;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];
  exp_t m_e;
  logic [3:0] m_s;
  vec_t tbl[25];

  lcd_bus_responder #(.SYNC_STAGES(2)) dut (
    .CLK_1MHz(clk), .RST(rst), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_DATA(lcd_data), .RD_ADDR(rd_addr), .RD_CHAR(rd_char), .AC(ac),
    .DISPLAY_ON(display_on), .CURSOR_ON(cursor_on), .BLINK_ON(blink_on), .INC_MODE(inc_mode),
    .FUNC_BITS(func_bits), .BUSY(busy), .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr),
    .WR_CHAR(wr_char), .CMD_STROBE(cmd_strobe), .CMD_CODE(cmd_code),
    .READ_SEEN(read_seen), .OVERRUN(overrun)
  );

  always #500 clk = ~clk;

  initial begin
    #50ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    m_s = {overrun, read_seen, cmd_strobe, wr_strobe};
    if (m_s != 4'b0000) begin
      if (sb.size() == 0) chk("unexpected_strobe", {28'd0, m_s}, 32'd0);
      else begin
        m_e = sb.pop_front();
        chk("strobe_kind", {28'd0, m_s}, {28'd0, m_e.kind});
        if (m_e.kind == K_WR) begin
          chk("wr_addr", {25'd0, wr_addr}, {25'd0, m_e.addr});
          chk("wr_char", {24'd0, wr_char}, {24'd0, m_e.val});
        end
        if (m_e.kind == K_CMD) begin
          chk("cmd_code", {24'd0, cmd_code}, {24'd0, m_e.val});
          if (m_e.val == 8'h01) chk("busy_with_clear", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d, input logic [3:0] kind, input logic [6:0] wa);
    sb.push_back('{kind, wa, d});
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic read_cell(input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("cell_%0d", a), {24'd0, rd_char}, {24'd0, exp});
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, 32);
  endtask

  task automatic wait_clear_strobe();
    int t = 0;
    while (!cmd_strobe && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("clear_strobe_seen", {31'd0, cmd_strobe}, 32'd1);
  endtask

  // data E falls n cycles after the clear strobe; n=29 lands in the last fill cycle, n=30 just after
  task automatic clear_edge(input int n, input logic [3:0] kind);
    sb.push_back('{K_CMD, 7'h00, 8'h01});
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    wait_clear_strobe();
    sb.push_back('{kind, 7'h00, 8'h36});
    lcd_rs = 1'b1; lcd_data = 8'h36; lcd_e = 1'b1;
    repeat (n) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    tbl = '{
      '{1'b0, 1'b0, 8'h38, K_CMD, 7'h00, 7'h00, 1'b1},
      '{1'b0, 1'b0, 8'h0C, K_CMD, 7'h00, 7'h00, 1'b1},
      '{1'b0, 1'b0, 8'h06, K_CMD, 7'h00, 7'h00, 1'b1},
      '{1'b1, 1'b0, 8'h32, K_WR,  7'h00, 7'h01, 1'b1},
      '{1'b1, 1'b0, 8'h34, K_WR,  7'h01, 7'h02, 1'b1},
      '{1'b0, 1'b0, 8'hC0, K_CMD, 7'h00, 7'h40, 1'b1},
      '{1'b1, 1'b0, 8'h2D, K_WR,  7'h40, 7'h41, 1'b1},
      '{1'b0, 1'b0, 8'hA7, K_CMD, 7'h00, 7'h27, 1'b1},
      '{1'b1, 1'b0, 8'h41, K_WR,  7'h27, 7'h40, 1'b1},
      '{1'b0, 1'b0, 8'hE7, K_CMD, 7'h00, 7'h67, 1'b1},
      '{1'b1, 1'b0, 8'h55, K_WR,  7'h67, 7'h00, 1'b1},
      '{1'b0, 1'b0, 8'h04, K_CMD, 7'h00, 7'h00, 1'b0},
      '{1'b0, 1'b0, 8'h80, K_CMD, 7'h00, 7'h00, 1'b0},
      '{1'b1, 1'b0, 8'h42, K_WR,  7'h00, 7'h67, 1'b0},
      '{1'b0, 1'b0, 8'h06, K_CMD, 7'h00, 7'h67, 1'b1},
      '{1'b0, 1'b0, 8'h40, K_CMD, 7'h00, 7'h67, 1'b1},
      '{1'b0, 1'b0, 8'h00, K_CMD, 7'h00, 7'h67, 1'b1},
      '{1'b0, 1'b1, 8'hFF, K_RD,  7'h00, 7'h67, 1'b1},
      '{1'b0, 1'b0, 8'hC0, K_CMD, 7'h00, 7'h40, 1'b1},
      '{1'b0, 1'b0, 8'h14, K_CMD, 7'h00, 7'h41, 1'b1},
      '{1'b0, 1'b0, 8'h10, K_CMD, 7'h00, 7'h40, 1'b1},
      '{1'b0, 1'b0, 8'h10, K_CMD, 7'h00, 7'h27, 1'b1},
      '{1'b0, 1'b0, 8'h18, K_CMD, 7'h00, 7'h27, 1'b1},
      '{1'b0, 1'b0, 8'h02, K_CMD, 7'h00, 7'h00, 1'b1},
      '{1'b1, 1'b1, 8'h77, K_RD,  7'h00, 7'h00, 1'b1}
    };
    @(negedge clk);
    chk("rst_ac", {25'd0, ac}, 32'd0);
    chk("rst_inc", {31'd0, inc_mode}, 32'd1);
    chk("rst_flags", {26'd0, display_on, cursor_on, blink_on, func_bits}, 32'd0);
    chk("rst_strobes", {28'd0, overrun, read_seen, cmd_strobe, wr_strobe}, 32'd0);
    chk("rst_wr", {17'd0, wr_addr, wr_char}, 32'd0);
    chk("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd_char", {24'd0, rd_char}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy("reset_busy_cycles");
    for (int i = 0; i < 32; i++) read_cell(5'(i), 8'h20);

    for (int i = 0; i < 25; i++) begin
      bus_xfer(tbl[i].rs, tbl[i].rw, tbl[i].d, tbl[i].kind, tbl[i].wa);
      chk($sformatf("ac_row%0d", i), {25'd0, ac}, {25'd0, tbl[i].ac});
      chk($sformatf("inc_row%0d", i), {31'd0, inc_mode}, {31'd0, tbl[i].inc});
    end
    chk("func_bits", {29'd0, func_bits}, 32'd6);
    chk("disp_cur_blink", {29'd0, display_on, cursor_on, blink_on}, 32'd4);
    read_cell(5'd0, 8'h42);
    read_cell(5'd1, 8'h34);
    read_cell(5'd2, 8'h20);
    read_cell(5'd16, 8'h2D);
    read_cell(5'd7, 8'h20);
    read_cell(5'd23, 8'h20);

    bus_xfer(1'b0, 1'b0, 8'h01, K_CMD, 7'h00);
    bus_xfer(1'b1, 1'b0, 8'h35, K_OV, 7'h00);
    chk("busy_after_overrun", {31'd0, busy}, 32'd1);
    begin
      int n = 0;
      while (busy && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("busy_fell", {31'd0, busy}, 32'd0);
    chk("clear_ac", {25'd0, ac}, 32'd0);
    for (int i = 0; i < 32; i++) read_cell(5'(i), 8'h20);
    bus_xfer(1'b1, 1'b0, 8'h35, K_WR, 7'h00);
    chk("ac_after_35", {25'd0, ac}, 32'd1);
    read_cell(5'd0, 8'h35);

    clear_edge(29, K_OV);
    read_cell(5'd0, 8'h20);
    chk("ac_after_late_drop", {25'd0, ac}, 32'd0);
    clear_edge(30, K_WR);
    read_cell(5'd0, 8'h36);
    chk("ac_after_first_accept", {25'd0, ac}, 32'd1);

    bus_xfer(1'b0, 1'b0, 8'h80, K_CMD, 7'h00);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{K_WR, 7'(i), 8'(8'h61 + i)});
      #($urandom_range(1, 999));
      lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'(8'h61 + i); lcd_e = 1'b1;
      #500us;
      lcd_e = 1'b0;
      #500us;
    end
    @(negedge clk);
    chk("async_ac", {25'd0, ac}, 32'd6);
    chk("async_sb_drained", sb.size(), 32'd0);
    for (int i = 0; i < 6; i++) read_cell(5'(i), 8'(8'h61 + i));

    sb.push_back('{K_CMD, 7'h00, 8'h01});
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    wait_clear_strobe();
    lcd_rs = 1'b1; lcd_data = 8'h99; lcd_e = 1'b1;
    repeat (15) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_fill_ac", {25'd0, ac}, 32'd0);
    chk("rst_mid_fill_flags", {26'd0, display_on, cursor_on, blink_on, func_bits}, 32'd0);
    count_busy("refill_busy_cycles");
    for (int i = 0; i < 6; i++) read_cell(5'(i), 8'h20);
    read_cell(5'd31, 8'h20);
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
